baccarat_sequencer: RTL and testbench

//  Moore controller that plays one hand of baccarat on the card datapath.
//  Per slow_clock cycle it asserts exactly one card-load strobe, or none.

---
 rtl/baccarat_sequencer.sv | 150 +++++++++++++++
 tb/tb_baccarat_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_sequencer.sv
// Moore sequencer for one baccarat hand: strobes card loads into the datapath,
// applies the natural / player-draw / banker-draw rules and latches the win lights.
//
// state     | meaning
// ----------+-----------------------------------------------
// DEAL_P1   | load player card 1
// DEAL_D1   | load dealer card 1
// DEAL_P2   | load player card 2
// DEAL_D2   | load dealer card 2
// EVAL      | two-card scores valid; natural / draw decision
// DEAL_P3   | load player card 3
// BANK_EVAL | banker draw table against player 3rd card value
// DEAL_D3   | load dealer card 3
// RESULT    | final scores valid; lights register on exit
// DONE      | hand finished; hold until reset
module baccarat_sequencer #(
    parameter logic [3:0] NATURAL_MIN     = 4'd8,
    parameter logic [3:0] PLAYER_DRAW_MAX = 4'd5,
    parameter logic [3:0] BANK_DRAW_MAX   = 4'd5
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pcard3,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       hand_done
);

    typedef enum logic [3:0] {
        DEAL_P1   = 4'd0,
        DEAL_D1   = 4'd1,
        DEAL_P2   = 4'd2,
        DEAL_D2   = 4'd3,
        EVAL      = 4'd4,
        DEAL_P3   = 4'd5,
        BANK_EVAL = 4'd6,
        DEAL_D3   = 4'd7,
        RESULT    = 4'd8,
        DONE      = 4'd9
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] p3_val;
    logic       bank_draw;

    // Face cards and tens count as zero.
    assign p3_val = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

    always_comb begin
        bank_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
            4'd3:             bank_draw = (p3_val != 4'd8);
            4'd4:             bank_draw = (p3_val >= 4'd2) && (p3_val <= 4'd7);
            4'd5:             bank_draw = (p3_val >= 4'd4) && (p3_val <= 4'd7);
            4'd6:             bank_draw = (p3_val >= 4'd6) && (p3_val <= 4'd7);
            default:          bank_draw = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state <= DEAL_P1;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        hand_done   = 1'b0;
        case (state)
            DEAL_P1: begin
                load_pcard1 = 1'b1;
                state_nxt   = DEAL_D1;
            end
            DEAL_D1: begin
                load_dcard1 = 1'b1;
                state_nxt   = DEAL_P2;
            end
            DEAL_P2: begin
                load_pcard2 = 1'b1;
                state_nxt   = DEAL_D2;
            end
            DEAL_D2: begin
                load_dcard2 = 1'b1;
                state_nxt   = EVAL;
            end
            EVAL: begin
                if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
                    state_nxt = RESULT;
                end else if (pscore <= PLAYER_DRAW_MAX) begin
                    state_nxt = DEAL_P3;
                end else if (dscore <= BANK_DRAW_MAX) begin
                    state_nxt = DEAL_D3;
                end else begin
                    state_nxt = RESULT;
                end
            end
            DEAL_P3: begin
                load_pcard3 = 1'b1;
                state_nxt   = BANK_EVAL;
            end
            BANK_EVAL: begin
                state_nxt = bank_draw ? DEAL_D3 : RESULT;
            end
            DEAL_D3: begin
                load_dcard3 = 1'b1;
                state_nxt   = RESULT;
            end
            RESULT: begin
                state_nxt = DONE;
            end
            DONE: begin
                hand_done = 1'b1;
                state_nxt = DONE;
            end
            default: begin
                state_nxt = DEAL_P1;
            end
        endcase
    end

    // Lights are only written on the RESULT -> DONE edge, so they stay dark elsewhere.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else if (state == RESULT) begin
            player_win_light <= (pscore >= dscore);
            dealer_win_light <= (dscore >= pscore);
        end
    end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Bench for baccarat_sequencer: a card datapath model feeds scores back, directed
// hands from the rulebook plus random hands against a rules-level reference.
module tb_baccarat_sequencer;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic [3:0] pcard3, pscore, dscore;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, hand_done;

    int checks = 0;
    int errors = 0;

    // card index: 0=p1 1=d1 2=p2 3=d2 4=p3 5=d3 (ranks 1..13)
    int card[6];
    int held[6];
    logic [5:0] strobes;

    logic [5:0] exp_trace[$];
    int         exp_lat;
    logic       exp_pw, exp_dw;

    logic [5:0] obs[20];
    int         done_edge;
    logic       obs_pw, obs_dw;
    bit         leak, unstable;

    baccarat_sequencer dut (
        .slow_clock      (slow_clock),
        .resetb          (resetb),
        .pcard3          (pcard3),
        .pscore          (pscore),
        .dscore          (dscore),
        .load_pcard1     (load_pcard1),
        .load_pcard2     (load_pcard2),
        .load_pcard3     (load_pcard3),
        .load_dcard1     (load_dcard1),
        .load_dcard2     (load_dcard2),
        .load_dcard3     (load_dcard3),
        .player_win_light(player_win_light),
        .dealer_win_light(dealer_win_light),
        .hand_done       (hand_done)
    );

    always #5 slow_clock = ~slow_clock;

    assign strobes = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};

    function automatic int cval(int r);
        return (r >= 10) ? 0 : r;
    endfunction

    // Datapath model: card registers capture on the edge that leaves the DEAL state.
    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 6; i++) held[i] <= 0;
        end else begin
            for (int i = 0; i < 6; i++) if (strobes[i]) held[i] <= card[i];
        end
    end

    always_comb begin
        pscore = 4'((cval(held[0]) + cval(held[2]) + cval(held[4])) % 10);
        dscore = 4'((cval(held[1]) + cval(held[3]) + cval(held[5])) % 10);
        pcard3 = 4'(card[4]);
    end

    always @(negedge slow_clock) begin
        if (resetb) begin
            checks++;
            if ($countones(strobes) > 1 || (hand_done && strobes != 6'd0)) begin
                errors++;
                $display("FAIL onehot t=%0t strobes=%b hand_done=%b required at most one strobe, none in DONE",
                         $time, strobes, hand_done);
            end
        end
    end

    function automatic bit banker_rule(int ds, int t);
        if (ds <= 2) return 1'b1;
        if (ds == 3) return t != 8;
        if (ds == 4) return t >= 2 && t <= 7;
        if (ds == 5) return t >= 4 && t <= 7;
        if (ds == 6) return t >= 6 && t <= 7;
        return 1'b0;
    endfunction

    task automatic build_expect();
        int ps, ds, t;
        bit natural, pdraw, bdraw;
        ps      = (cval(card[0]) + cval(card[2])) % 10;
        ds      = (cval(card[1]) + cval(card[3])) % 10;
        t       = cval(card[4]);
        natural = (ps >= 8) || (ds >= 8);
        pdraw   = !natural && (ps <= 5);
        if (natural)    bdraw = 1'b0;
        else if (pdraw) bdraw = banker_rule(ds, t);
        else            bdraw = (ds <= 5);
        if (pdraw) ps = (ps + t) % 10;
        if (bdraw) ds = (ds + cval(card[5])) % 10;
        exp_pw = (ps >= ds);
        exp_dw = (ds >= ps);
        exp_trace = {};
        exp_trace.push_back(6'h01); exp_trace.push_back(6'h02);
        exp_trace.push_back(6'h04); exp_trace.push_back(6'h08);
        exp_trace.push_back(6'h00);
        if (pdraw) begin exp_trace.push_back(6'h10); exp_trace.push_back(6'h00); end
        if (bdraw) exp_trace.push_back(6'h20);
        exp_trace.push_back(6'h00);
        exp_lat = 6 + (pdraw ? 2 : 0) + (bdraw ? 1 : 0);
    endtask

    task automatic set_cards(int p1, int p2, int d1, int d2, int p3, int d3);
        card[0] = p1; card[1] = d1; card[2] = p2; card[3] = d2; card[4] = p3; card[5] = d3;
    endtask

    // Called on a negedge; holds reset across one posedge and releases on the next negedge.
    task automatic start_hand();
        resetb = 1'b0;
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    task automatic observe_hand();
        done_edge = -1; leak = 0; unstable = 0;
        for (int n = 0; n < 20; n++) begin
            obs[n] = strobes;
            if (hand_done) begin
                done_edge = n;
                break;
            end
            if (player_win_light || dealer_win_light) leak = 1;
            @(negedge slow_clock);
        end
        obs_pw = player_win_light;
        obs_dw = dealer_win_light;
        for (int k = 0; k < 3; k++) begin
            @(negedge slow_clock);
            if (!hand_done || player_win_light !== obs_pw || dealer_win_light !== obs_dw) unstable = 1;
        end
    endtask

    task automatic test_reset();
        @(negedge slow_clock);
        checks++;
        if (strobes !== 6'h01 || player_win_light !== 1'b0 || dealer_win_light !== 1'b0 || hand_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state strobes=%b lights=%b%b done=%b required 000001 00 0",
                     strobes, player_win_light, dealer_win_light, hand_done);
        end
        set_cards(3, 5, 1, 2, 1, 1);
        start_hand();
        observe_hand();
        resetb = 1'b0;
        #1;
        checks++;
        if (strobes !== 6'h01 || player_win_light !== 1'b0 || dealer_win_light !== 1'b0 || hand_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_from_done strobes=%b lights=%b%b done=%b required 000001 00 0",
                     strobes, player_win_light, dealer_win_light, hand_done);
        end
        @(negedge slow_clock);
    endtask

    task automatic test_natural();
        bit third;
        set_cards(3, 5, 1, 2, 9, 9);
        start_hand();
        observe_hand();
        third = 0;
        for (int n = 0; n < 6; n++) if (obs[n][5:4] != 2'b00) third = 1;
        checks++;
        if (done_edge !== 6) begin errors++; $display("FAIL natural_latency got %0d required 6", done_edge); end
        checks++;
        if (third) begin errors++; $display("FAIL natural_third_card got a 3rd-card strobe required none"); end
        checks++;
        if ({obs_pw, obs_dw} !== 2'b10) begin errors++; $display("FAIL natural_lights got %b%b required 10", obs_pw, obs_dw); end
        checks++;
        if (leak || unstable) begin errors++; $display("FAIL natural_hold leak=%0d unstable=%0d required 0 0", leak, unstable); end
    endtask

    task automatic test_both_stand();
        set_cards(2, 4, 3, 4, 1, 1);
        start_hand();
        observe_hand();
        checks++;
        if (done_edge !== 6) begin errors++; $display("FAIL stand_latency got %0d required 6", done_edge); end
        checks++;
        if ({obs_pw, obs_dw} !== 2'b01) begin errors++; $display("FAIL stand_lights got %b%b required 01", obs_pw, obs_dw); end
    endtask

    task automatic test_bank_stand();
        bit d3;
        set_cards(1, 3, 1, 2, 8, 5);
        start_hand();
        observe_hand();
        d3 = 0;
        for (int n = 0; n < 9; n++) if (obs[n][5]) d3 = 1;
        checks++;
        if (obs[5] !== 6'h10) begin errors++; $display("FAIL bank3_p3_strobe got %b required 010000", obs[5]); end
        checks++;
        if (d3) begin errors++; $display("FAIL bank3_no_d3 got load_dcard3 required none"); end
        checks++;
        if (done_edge !== 8) begin errors++; $display("FAIL bank3_latency got %0d required 8", done_edge); end
        checks++;
        if ({obs_pw, obs_dw} !== 2'b01) begin errors++; $display("FAIL bank3_lights got %b%b required 01", obs_pw, obs_dw); end
    endtask

    task automatic test_full_hand();
        int pulses;
        set_cards(1, 1, 2, 4, 7, 3);
        start_hand();
        observe_hand();
        pulses = 0;
        for (int n = 0; n < 9; n++) if (obs[n][5]) pulses++;
        checks++;
        if (obs[7] !== 6'h20 || pulses != 1) begin
            errors++; $display("FAIL full_d3_pulse got obs7=%b pulses=%0d required 100000 1", obs[7], pulses);
        end
        checks++;
        if (done_edge !== 9) begin errors++; $display("FAIL full_latency got %0d required 9", done_edge); end
        checks++;
        if ({obs_pw, obs_dw} !== 2'b11) begin errors++; $display("FAIL full_lights got %b%b required 11", obs_pw, obs_dw); end
    endtask

    task automatic test_face_card();
        set_cards(1, 1, 2, 2, 12, 4);
        start_hand();
        observe_hand();
        checks++;
        if (done_edge !== 8 || obs[7] !== 6'h00) begin
            errors++; $display("FAIL face_stand got edge=%0d obs7=%b required 8 000000", done_edge, obs[7]);
        end
        set_cards(1, 1, 2, 2, 3, 4);
        start_hand();
        observe_hand();
        checks++;
        if (done_edge !== 9 || obs[7] !== 6'h20) begin
            errors++; $display("FAIL face_draw got edge=%0d obs7=%b required 9 100000", done_edge, obs[7]);
        end
    endtask

    task automatic test_reset_mid_hand();
        bit seen;
        set_cards(1, 1, 2, 4, 7, 3);
        start_hand();
        seen = 0;
        for (int n = 0; n < 12 && !seen; n++) begin
            if (load_pcard3) seen = 1;
            else @(negedge slow_clock);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midreset_reach got no load_pcard3 required one within 12 cycles"); end
        resetb = 1'b0;
        #1;
        checks++;
        if (strobes !== 6'h01 || player_win_light !== 1'b0 || dealer_win_light !== 1'b0 || hand_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state strobes=%b lights=%b%b done=%b required 000001 00 0",
                     strobes, player_win_light, dealer_win_light, hand_done);
        end
        @(negedge slow_clock);
        resetb = 1'b1;
        observe_hand();
        checks++;
        if (done_edge !== 9 || obs[7] !== 6'h20 || {obs_pw, obs_dw} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_replay got edge=%0d obs7=%b lights=%b%b required 9 100000 11",
                     done_edge, obs[7], obs_pw, obs_dw);
        end
    endtask

    task automatic test_random();
        for (int h = 0; h < 60; h++) begin
            set_cards($urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13),
                      $urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13));
            build_expect();
            start_hand();
            observe_hand();
            checks++;
            if (done_edge !== exp_lat) begin
                errors++; $display("FAIL rand%0d_latency got %0d required %0d", h, done_edge, exp_lat);
            end
            checks++;
            if ({obs_pw, obs_dw} !== {exp_pw, exp_dw}) begin
                errors++; $display("FAIL rand%0d_lights got %b%b required %b%b", h, obs_pw, obs_dw, exp_pw, exp_dw);
            end
            for (int n = 0; n < exp_trace.size(); n++) begin
                checks++;
                if (obs[n] !== exp_trace[n]) begin
                    errors++; $display("FAIL rand%0d_strobe%0d got %b required %b", h, n, obs[n], exp_trace[n]);
                end
            end
            checks++;
            if (leak || unstable) begin
                errors++; $display("FAIL rand%0d_hold leak=%0d unstable=%0d required 0 0", h, leak, unstable);
            end
        end
    endtask

    initial begin
        set_cards(1, 1, 1, 1, 1, 1);
        test_reset();
        test_natural();
        test_both_stand();
        test_bank_stand();
        test_full_hand();
        test_face_card();
        test_reset_mid_hand();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
